// File: rtl/lcd_field_render_if.sv
// Bus bundle for lcd_field_render.
//
// There is no valid/ready handshake on this bus. The renderer free-runs:
// field_val/field_en are sampled only during each field's LATCH cycle, and
// row_A/row_B change only in the cycle frame_done is high. Outside that
// cycle the rows are stable and may be read at any time.
//
//   field_val  : NUM_FIELDS packed values, field i at [i*FIELD_W +: FIELD_W]
//   field_en   : per-field enable, 0 renders the field as spaces
//   row_A/B    : 16 ASCII chars each, column c at [127-8c -: 8]
//   busy       : high every cycle outside reset
//   frame_done : one-cycle pulse in the cycle the rows update
//   state_dbg  : current FSM state, for observation only
interface lcd_field_render_if #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 16
);
  logic [NUM_FIELDS*FIELD_W-1:0] field_val;
  logic [NUM_FIELDS-1:0]         field_en;
  logic [127:0]                  row_A;
  logic [127:0]                  row_B;
  logic                          busy;
  logic                          frame_done;
  logic [1:0]                    state_dbg;

  modport master (
    output field_val, field_en,
    input  row_A, row_B, busy, frame_done, state_dbg
  );

  modport slave (
    input  field_val, field_en,
    output row_A, row_B, busy, frame_done, state_dbg
  );
endinterface

// File: rtl/lcd_field_render.sv
// Hex/decimal text renderer for the two 16-character LCD rows.
//
// Free-running: each field is latched, converted (hex nibble-serial or
// decimal double-dabble), and written into a shadow row. After the last
// field both shadow rows are copied to row_A/row_B together and
// frame_done pulses; the shadows are then cleared to spaces.
//
// Ports:
//   clk    : design clock (clk_50MHz domain)
//   reset  : synchronous, active-high
//   bus    : lcd_field_render_if.slave (inputs field_val/field_en,
//            outputs row_A/row_B/busy/frame_done/state_dbg)
module lcd_field_render #(
  parameter int                        NUM_FIELDS  = 4,
  parameter int                        FIELD_W     = 16,
  parameter int                        DIGITS      = 4,
  parameter logic [NUM_FIELDS-1:0]     FIELD_ROW   = 4'b1100,
  parameter logic [4*NUM_FIELDS-1:0]   FIELD_COL   = 16'h8080,
  parameter logic [NUM_FIELDS-1:0]     FIELD_DEC   = 4'b0100,
  parameter logic [NUM_FIELDS-1:0]     FIELD_BLANK = 4'b0100
) (
  input  logic                clk,
  input  logic                reset,
  lcd_field_render_if.slave   bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = 6;
  localparam int FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [63:0]  DEC_LIMIT = 64'd10 ** DIGITS;
  localparam logic [127:0] SPACES    = {16{8'h20}};

  // A field that would run past column 15 is a configuration mistake.
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_col_chk
    if (int'(FIELD_COL[4*g +: 4]) + DIGITS > 16) begin : g_bad
      $error("lcd_field_render: field %0d does not fit in a 16-column row", g);
    end
  end

  typedef enum logic [1:0] {
    S_LATCH  = 2'd0,
    S_CONV   = 2'd1,
    S_WRITE  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t              state;
  logic [FIDX_W-1:0]   fidx;
  logic [CNT_W-1:0]    cnt;
  logic [FIELD_W-1:0]  work;
  logic [BCD_W-1:0]    dig;     // digit k at [4k +: 4], k = 0 least significant
  logic                en_q;
  logic                ovf_q;
  logic [127:0]        shadow_a;
  logic [127:0]        shadow_b;
  logic [127:0]        row_a_q;
  logic [127:0]        row_b_q;
  logic                busy_q;
  logic                frame_done_q;

  // Per-field configuration for the field currently in flight.
  logic       cur_dec;
  logic       cur_blank;
  logic       cur_row;
  logic [3:0] cur_col;

  always_comb begin
    cur_dec   = FIELD_DEC[fidx];
    cur_blank = FIELD_BLANK[fidx];
    cur_row   = FIELD_ROW[fidx];
    cur_col   = FIELD_COL[{fidx, 2'b00} +: 4];
  end

  // Input selection and overflow test, used in the LATCH cycle. Overflow is
  // decided on the full input value so the truncated conversion result
  // never has to be trusted for it.
  logic [FIELD_W-1:0] in_val;
  logic [63:0]        in_val64;
  logic               in_ovf;

  always_comb begin
    in_val   = bus.field_val[int'(fidx)*FIELD_W +: FIELD_W];
    in_val64 = 64'(in_val);
    if (cur_dec) in_ovf = (in_val64 >= DEC_LIMIT);
    else         in_ovf = ((in_val64 >> BCD_W) != 64'd0);
  end

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  logic [BCD_W-1:0] dig_adj;

  always_comb begin
    dig_adj = dig;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig[4*k +: 4] >= 4'd5) dig_adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
    end
  end

  // Character generation from the converted digits. 'lead' stays set while
  // scanning from the most significant digit through zeros; the least
  // significant digit is never blanked so a zero value shows "0".
  logic [7:0] chars [DIGITS];

  always_comb begin : p_chars
    logic       lead;
    logic [3:0] nib;
    for (int k = 0; k < DIGITS; k++) chars[k] = 8'h20;
    lead = 1'b1;
    nib  = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = dig[4*k +: 4];
      if (nib != 4'd0 || k == 0) lead = 1'b0;
      if (!en_q)                  chars[k] = 8'h20;
      else if (ovf_q)             chars[k] = 8'h2A;
      else if (cur_blank && lead) chars[k] = 8'h20;
      else if (nib < 4'd10)       chars[k] = 8'h30 + {4'd0, nib};
      else                        chars[k] = 8'h37 + {4'd0, nib};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LATCH;
      fidx         <= '0;
      cnt          <= '0;
      work         <= '0;
      dig          <= '0;
      en_q         <= 1'b0;
      ovf_q        <= 1'b0;
      shadow_a     <= SPACES;
      shadow_b     <= SPACES;
      row_a_q      <= SPACES;
      row_b_q      <= SPACES;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      case (state)
        S_LATCH: begin
          work  <= in_val;
          en_q  <= bus.field_en[fidx];
          ovf_q <= in_ovf;
          dig   <= '0;
          cnt   <= '0;
          state <= S_CONV;
        end

        S_CONV: begin
          if (cur_dec) begin
            // MSB of the value shifts into the bottom of the BCD register.
            dig  <= (dig_adj << 1) | BCD_W'(work[FIELD_W-1]);
            work <= work << 1;
            if (cnt == CNT_W'(FIELD_W - 1)) state <= S_WRITE;
          end else begin
            // Low nibble enters at the top; after DIGITS shifts nibble 0
            // sits at digit 0.
            dig  <= (dig >> 4) | (BCD_W'(work[3:0]) << (BCD_W - 4));
            work <= work >> 4;
            if (cnt == CNT_W'(DIGITS - 1)) state <= S_WRITE;
          end
          cnt <= cnt + 1'b1;
        end

        S_WRITE: begin
          // Leftmost column gets the most significant digit.
          for (int j = 0; j < DIGITS; j++) begin
            if (cur_row) shadow_b[8*(15 - (int'(cur_col) + j)) +: 8] <= chars[DIGITS-1-j];
            else         shadow_a[8*(15 - (int'(cur_col) + j)) +: 8] <= chars[DIGITS-1-j];
          end
          if (fidx == FIDX_W'(NUM_FIELDS - 1)) begin
            state <= S_COMMIT;
          end else begin
            fidx  <= fidx + 1'b1;
            state <= S_LATCH;
          end
        end

        S_COMMIT: begin
          row_a_q      <= shadow_a;
          row_b_q      <= shadow_b;
          frame_done_q <= 1'b1;
          shadow_a     <= SPACES;
          shadow_b     <= SPACES;
          fidx         <= '0;
          state        <= S_LATCH;
        end

        default: state <= S_LATCH;
      endcase
    end
  end

  assign bus.row_A      = row_a_q;
  assign bus.row_B      = row_b_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state_dbg  = state;

endmodule
